// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the accumulator CPU: owns pc, ir and operand,
// and steps each instruction through fetch/decode/memory/ALU/IO phases.
module cpu_control_unit #(
    parameter int ADDR_BITS = 8,
    parameter int CMD_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    output logic [ADDR_BITS-1:0] pc,
    input  logic [CMD_BITS-1:0]  rom_cmd,
    input  logic [ADDR_BITS-1:0] rom_operand,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic                 ram_re,
    output logic                 ram_we,
    input  logic                 acc_zero,
    output logic                 acc_load,
    output logic [1:0]           acc_src,
    output logic [1:0]           alu_op,
    output logic                 alu_start,
    input  logic                 alu_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 in_valid,
    output logic                 in_ack,
    output logic [CMD_BITS-1:0]  cmd_out,
    output logic                 halted,
    output logic                 illegal
);

    localparam logic [CMD_BITS-1:0] OP_NOP  = CMD_BITS'(8'h00);
    localparam logic [CMD_BITS-1:0] OP_LOAD = CMD_BITS'(8'h01);
    localparam logic [CMD_BITS-1:0] OP_STO  = CMD_BITS'(8'h02);
    localparam logic [CMD_BITS-1:0] OP_SUM  = CMD_BITS'(8'h03);
    localparam logic [CMD_BITS-1:0] OP_SUB  = CMD_BITS'(8'h04);
    localparam logic [CMD_BITS-1:0] OP_MULT = CMD_BITS'(8'h05);
    localparam logic [CMD_BITS-1:0] OP_DIV  = CMD_BITS'(8'h06);
    localparam logic [CMD_BITS-1:0] OP_JUMP = CMD_BITS'(8'h07);
    localparam logic [CMD_BITS-1:0] OP_TST  = CMD_BITS'(8'h08);
    localparam logic [CMD_BITS-1:0] OP_OUT  = CMD_BITS'(8'h09);
    localparam logic [CMD_BITS-1:0] OP_IN   = CMD_BITS'(8'h0A);
    localparam logic [CMD_BITS-1:0] OP_HALT = '1;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        WAIT_ALU,
        MEM_WR,
        IO_OUT,
        IO_IN,
        HALT
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [ADDR_BITS-1:0] pc_q;
    logic [ADDR_BITS-1:0] pc_n;
    logic [ADDR_BITS-1:0] pc_inc;
    logic [ADDR_BITS-1:0] pc_skip;
    logic [CMD_BITS-1:0]  ir;
    logic [ADDR_BITS-1:0] opr;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 illegal_q;
    logic                 fetch_en;
    logic                 addr_en;
    logic                 ill_set;

    logic op_nop;
    logic op_load;
    logic op_sto;
    logic op_sum;
    logic op_sub;
    logic op_mult;
    logic op_div;
    logic op_jump;
    logic op_tst;
    logic op_out;
    logic op_in;
    logic op_halt;
    logic op_alu;
    logic op_bad;
    logic [1:0] alu_code;

    assign op_nop  = (ir == OP_NOP);
    assign op_load = (ir == OP_LOAD);
    assign op_sto  = (ir == OP_STO);
    assign op_sum  = (ir == OP_SUM);
    assign op_sub  = (ir == OP_SUB);
    assign op_mult = (ir == OP_MULT);
    assign op_div  = (ir == OP_DIV);
    assign op_jump = (ir == OP_JUMP);
    assign op_tst  = (ir == OP_TST);
    assign op_out  = (ir == OP_OUT);
    assign op_in   = (ir == OP_IN);
    assign op_halt = (ir == OP_HALT);
    assign op_alu  = op_sum | op_sub | op_mult | op_div;
    assign op_bad  = ~(op_nop | op_load | op_sto | op_alu | op_jump |
                       op_tst | op_out | op_in | op_halt);

    always_comb begin
        alu_code = 2'd0;
        if (op_sub) begin
            alu_code = 2'd1;
        end else if (op_mult) begin
            alu_code = 2'd2;
        end else if (op_div) begin
            alu_code = 2'd3;
        end
    end

    // Wraps modulo 2^ADDR_BITS by construction.
    assign pc_inc  = pc_q + ADDR_BITS'(1);
    assign pc_skip = pc_q + ADDR_BITS'(2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            pc_q      <= '0;
            ir        <= '0;
            opr       <= '0;
            addr_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            if (fetch_en) begin
                ir  <= rom_cmd;
                opr <= rom_operand;
            end
            if (addr_en) begin
                addr_q <= opr;
            end
            if (ill_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        fetch_en  = 1'b0;
        addr_en   = 1'b0;
        ill_set   = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        acc_load  = 1'b0;
        acc_src   = 2'd0;
        alu_op    = 2'd0;
        alu_start = 1'b0;
        out_valid = 1'b0;
        in_ack    = 1'b0;
        unique case (state)
            FETCH: begin
                if (run) begin
                    fetch_en = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                unique case (1'b1)
                    op_nop: begin
                        pc_n    = pc_inc;
                        state_n = FETCH;
                    end
                    op_jump: begin
                        pc_n    = opr;
                        state_n = FETCH;
                    end
                    op_tst: begin
                        pc_n    = acc_zero ? pc_skip : pc_inc;
                        state_n = FETCH;
                    end
                    op_load, op_alu: begin
                        addr_en = 1'b1;
                        state_n = MEM_RD;
                    end
                    op_sto: begin
                        addr_en = 1'b1;
                        state_n = MEM_WR;
                    end
                    op_out:  state_n = IO_OUT;
                    op_in:   state_n = IO_IN;
                    op_halt: state_n = HALT;
                    op_bad: begin
                        ill_set = 1'b1;
                        state_n = HALT;
                    end
                    default: state_n = HALT;
                endcase
            end
            MEM_RD: begin
                ram_re = 1'b1;
                alu_op = alu_code;
                if (op_load) begin
                    acc_load = 1'b1;
                    acc_src  = 2'd1;
                    pc_n     = pc_inc;
                    state_n  = FETCH;
                end else begin
                    alu_start = 1'b1;
                    state_n   = WAIT_ALU;
                end
            end
            // alu_done during the launch cycle is never seen here.
            WAIT_ALU: begin
                ram_re = 1'b1;
                alu_op = alu_code;
                if (alu_done) begin
                    acc_load = 1'b1;
                    pc_n     = pc_inc;
                    state_n  = FETCH;
                end
            end
            MEM_WR: begin
                ram_we  = 1'b1;
                pc_n    = pc_inc;
                state_n = FETCH;
            end
            IO_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end
            end
            IO_IN: begin
                if (in_valid) begin
                    in_ack   = 1'b1;
                    acc_load = 1'b1;
                    acc_src  = 2'd2;
                    pc_n     = pc_inc;
                    state_n  = FETCH;
                end
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    assign pc       = pc_q;
    assign ram_addr = addr_q;
    assign cmd_out  = ir;
    assign halted   = (state == HALT);
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Cycle-accurate scoreboard bench for cpu_control_unit with a small ROM
// model driven from the DUT program counter.
module tb_cpu_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] pc;
    logic [7:0] rom_cmd;
    logic [7:0] rom_operand;
    logic [7:0] ram_addr;
    logic       ram_re;
    logic       ram_we;
    logic       acc_zero;
    logic       acc_load;
    logic [1:0] acc_src;
    logic [1:0] alu_op;
    logic       alu_start;
    logic       alu_done;
    logic       out_valid;
    logic       out_ready;
    logic       in_valid;
    logic       in_ack;
    logic [7:0] cmd_out;
    logic       halted;
    logic       illegal;

    always #5 clock = ~clock;

    cpu_control_unit #(.ADDR_BITS(8), .CMD_BITS(8)) dut (
        .clock(clock), .reset(reset), .run(run), .pc(pc),
        .rom_cmd(rom_cmd), .rom_operand(rom_operand),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .acc_zero(acc_zero), .acc_load(acc_load), .acc_src(acc_src),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_valid(in_valid), .in_ack(in_ack), .cmd_out(cmd_out),
        .halted(halted), .illegal(illegal)
    );

    logic [7:0] cmd_mem [256];
    logic [7:0] opr_mem [256];

    assign rom_cmd     = cmd_mem[pc];
    assign rom_operand = opr_mem[pc];

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ra;
        logic       re;
        logic       we;
        logic       ld;
        logic [1:0] src;
        logic       st;
        logic [1:0] op;
        logic       ov;
        logic       ack;
        logic       h;
        logic       il;
    } obs_t;

    obs_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur   = "init";

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pc  = pc;
        o.ra  = ram_addr;
        o.re  = ram_re;
        o.we  = ram_we;
        o.ld  = acc_load;
        o.src = acc_src;
        o.st  = alu_start;
        o.op  = alu_op;
        o.ov  = out_valid;
        o.ack = in_ack;
        o.h   = halted;
        o.il  = illegal;
        return o;
    endfunction

    function automatic obs_t mk(input int p, input int ra, input int re,
                                input int we, input int ld, input int src,
                                input int st, input int op, input int ov,
                                input int ack, input int h, input int il);
        obs_t o;
        o.pc  = 8'(p);
        o.ra  = 8'(ra);
        o.re  = 1'(re);
        o.we  = 1'(we);
        o.ld  = 1'(ld);
        o.src = 2'(src);
        o.st  = 1'(st);
        o.op  = 2'(op);
        o.ov  = 1'(ov);
        o.ack = 1'(ack);
        o.h   = 1'(h);
        o.il  = 1'(il);
        return o;
    endfunction

    function automatic obs_t idle(input int p, input int ra);
        return mk(p, ra, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
    task automatic step(input int r, input int d, input int rdy,
                        input int iv, input int az, input obs_t x);
        obs_t got;
        run       = 1'(r);
        alu_done  = 1'(d);
        out_ready = 1'(rdy);
        in_valid  = 1'(iv);
        acc_zero  = 1'(az);
        exp_q.push_back(x);
        @(negedge clock);
        got = sample();
        check(cur, 64'(got), 64'(exp_q.pop_front()));
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        run       = 1'b0;
        alu_done  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        acc_zero  = 1'b0;
        #1;
        check("reset_outs", 64'(sample()), 64'(idle(0, 0)));
        check("reset_cmd", 64'(cmd_out), 64'(8'h00));
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            cmd_mem[i] = 8'h00;
            opr_mem[i] = 8'h00;
        end
        cmd_mem[8'h00] = 8'h01; opr_mem[8'h00] = 8'h10;
        cmd_mem[8'h01] = 8'h03; opr_mem[8'h01] = 8'h11;
        cmd_mem[8'h02] = 8'h02; opr_mem[8'h02] = 8'h12;
        cmd_mem[8'h03] = 8'h06; opr_mem[8'h03] = 8'h20;
        cmd_mem[8'h04] = 8'h09;
        cmd_mem[8'h05] = 8'h0A;
        cmd_mem[8'h06] = 8'h07; opr_mem[8'h06] = 8'h40;
        cmd_mem[8'h40] = 8'h07; opr_mem[8'h40] = 8'hFF;
        cmd_mem[8'hFF] = 8'h08;

        reset     = 1'b1;
        run       = 1'b0;
        alu_done  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        acc_zero  = 1'b0;
        #2;
        do_reset();

        cur = "load_sum_sto";
        step(1, 1, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 1, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 1, 0, 0, 0, mk(8'h00, 8'h10, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0, idle(8'h01, 8'h10));
        step(1, 1, 0, 0, 0, idle(8'h01, 8'h10));
        step(1, 1, 0, 0, 0, mk(8'h01, 8'h11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0, mk(8'h01, 8'h11, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0, idle(8'h02, 8'h11));
        step(1, 1, 0, 0, 0, idle(8'h02, 8'h11));
        step(1, 1, 0, 0, 0, mk(8'h02, 8'h12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        cur = "div_slow";
        step(1, 0, 0, 0, 0, idle(8'h03, 8'h12));
        step(1, 0, 0, 0, 0, idle(8'h03, 8'h12));
        step(1, 1, 0, 0, 0, mk(8'h03, 8'h20, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, mk(8'h03, 8'h20, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        step(1, 1, 0, 0, 0, mk(8'h03, 8'h20, 1, 0, 1, 0, 0, 3, 0, 0, 0, 0));

        cur = "out_wait";
        step(1, 0, 0, 0, 0, idle(8'h04, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h04, 8'h20));
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 0, 0, mk(8'h04, 8'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step(1, 0, 1, 0, 0, mk(8'h04, 8'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        cur = "in_late";
        step(1, 0, 0, 0, 0, idle(8'h05, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h05, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h05, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h05, 8'h20));
        step(1, 0, 0, 1, 0, mk(8'h05, 8'h20, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0));

        cur = "jump_tst_skip";
        step(1, 0, 0, 0, 0, idle(8'h06, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h06, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h40, 8'h20));
        step(1, 0, 0, 0, 0, idle(8'h40, 8'h20));
        step(1, 0, 0, 0, 1, idle(8'hFF, 8'h20));
        step(0, 0, 0, 0, 1, idle(8'hFF, 8'h20));
        step(0, 0, 0, 0, 1, idle(8'h01, 8'h20));
        step(0, 0, 0, 0, 1, idle(8'h01, 8'h20));

        do_reset();
        cmd_mem[8'h00] = 8'h07; opr_mem[8'h00] = 8'hFF;
        cur = "tst_noskip_wrap";
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'hFF, 8'h00));
        step(0, 0, 0, 0, 0, idle(8'hFF, 8'h00));
        step(0, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(0, 0, 0, 0, 0, idle(8'h00, 8'h00));

        do_reset();
        opr_mem[8'h00] = 8'h30;
        cmd_mem[8'h30] = 8'h09;
        cur = "rst_mid_out";
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h30, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h30, 8'h00));
        step(1, 0, 0, 0, 0, mk(8'h30, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        #2;
        check("pre_rst_ov", 64'(out_valid), 64'(1'b1));
        reset = 1'b0;
        #1;
        check("async_rst_ov", 64'(out_valid), 64'(1'b0));
        check("async_rst_pc", 64'(pc), 64'(8'h00));
        @(posedge clock);
        #1;
        reset = 1'b1;
        cur = "after_rst_fetch";
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));

        do_reset();
        cmd_mem[8'h00] = 8'h3C;
        cur = "illegal_halt";
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(1, 0, 0, 0, 0, idle(8'h00, 8'h00));
        step(0, 0, 0, 0, 0, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(1, 0, 0, 0, 0, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(0, 0, 1, 1, 1, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        step(1, 1, 0, 0, 0, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        check("illegal_cmd", 64'(cmd_out), 64'(8'h3C));
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
